// File: rtl/light_sequencer.sv
// Traffic-light sequencer for a main/side intersection with a pedestrian walk phase.
// Every state entry reloads an external interval timer; expiries are honoured only once armed.
module light_sequencer #(
  parameter logic [3:0] T_BASE = 4'd6,
  parameter logic [3:0] T_EXT  = 4'd3,
  parameter logic [3:0] T_YEL  = 4'd2
) (
  input  logic       clk,
  input  logic       sys_reset,
  input  logic       sensor,
  input  logic       walk_request,
  input  logic       expired,
  output logic       start_timer,
  output logic [3:0] timer_value,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk
);

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef enum logic [2:0] {
    INIT, MAIN_GO, MAIN_EXT, MAIN_YEL, SIDE_GO, SIDE_EXT, SIDE_YEL, WALK
  } state_t;

  state_t state_reg;
  state_t state_next;
  logic   armed_reg;
  logic   walk_pending_reg;
  logic   fire;
  logic   enter;

  function automatic logic [3:0] interval_of(input state_t s);
    case (s)
      MAIN_GO, SIDE_GO:            interval_of = T_BASE;
      MAIN_EXT, SIDE_EXT, WALK:    interval_of = T_EXT;
      MAIN_YEL, SIDE_YEL:          interval_of = T_YEL;
      default:                     interval_of = 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] main_lamp_of(input state_t s);
    case (s)
      MAIN_GO, MAIN_EXT: main_lamp_of = LAMP_G;
      MAIN_YEL:          main_lamp_of = LAMP_Y;
      default:           main_lamp_of = LAMP_R;
    endcase
  endfunction

  function automatic logic [2:0] side_lamp_of(input state_t s);
    case (s)
      SIDE_GO, SIDE_EXT: side_lamp_of = LAMP_G;
      SIDE_YEL:          side_lamp_of = LAMP_Y;
      default:           side_lamp_of = LAMP_R;
    endcase
  endfunction

  always_comb begin
    fire       = armed_reg && expired;
    state_next = state_reg;
    case (state_reg)
      INIT:     state_next = MAIN_GO;
      MAIN_GO:  if (fire) state_next = sensor ? MAIN_YEL : MAIN_EXT;
      MAIN_EXT: if (fire) state_next = MAIN_YEL;
      MAIN_YEL: if (fire) state_next = walk_pending_reg ? WALK : SIDE_GO;
      SIDE_GO:  if (fire) state_next = sensor ? SIDE_EXT : SIDE_YEL;
      SIDE_EXT: if (fire) state_next = SIDE_YEL;
      SIDE_YEL: if (fire) state_next = MAIN_GO;
      WALK:     if (fire) state_next = SIDE_GO;
      default:  state_next = INIT;
    endcase
    // No state has a self-loop, so any change of state is an entry.
    enter = (state_next != state_reg);
  end

  always_ff @(posedge clk) begin
    if (!sys_reset) begin
      state_reg        <= INIT;
      main_light       <= LAMP_R;
      side_light       <= LAMP_R;
      walk             <= 1'b0;
      start_timer      <= 1'b0;
      timer_value      <= 4'd0;
      armed_reg        <= 1'b0;
      walk_pending_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      start_timer <= enter;
      if (enter) timer_value <= interval_of(state_next);
      main_light  <= main_lamp_of(state_next);
      side_light  <= side_lamp_of(state_next);
      walk        <= (state_next == WALK);
      // Disarmed through the load cycle and the one after, so a stale expiry
      // still asserted by the timer cannot trigger a second transition.
      armed_reg   <= !(enter || start_timer);
      if (state_reg == MAIN_YEL && state_next == WALK)
        walk_pending_reg <= 1'b0;
      else if (walk_request)
        walk_pending_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_light_sequencer.sv
// Bench for light_sequencer: directed vector table, hand-written phase sequences,
// and a randomized run against a phase-table reference model.
module tb_light_sequencer;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       sys_reset = 1'b0;
  logic       sensor = 1'b0;
  logic       walk_request = 1'b0;
  logic       expired = 1'b0;
  logic       start_timer;
  logic [3:0] timer_value;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;

  light_sequencer dut (
    .clk(clk), .sys_reset(sys_reset), .sensor(sensor), .walk_request(walk_request),
    .expired(expired), .start_timer(start_timer), .timer_value(timer_value),
    .main_light(main_light), .side_light(side_light), .walk(walk)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic        rst;
    logic        sens;
    logic        wreq;
    logic        ex;
    logic [11:0] want;   // {start_timer, timer_value, main, side, walk}
    string       note;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic rst, input logic sens, input logic wreq, input logic ex,
                              input logic st, input logic [3:0] tv, input logic [2:0] m,
                              input logic [2:0] s, input logic w, input string note);
    vec_t v;
    v.rst = rst; v.sens = sens; v.wreq = wreq; v.ex = ex;
    v.want = {st, tv, m, s, w};
    v.note = note;
    return v;
  endfunction

  function automatic logic [11:0] obs();
    return {start_timer, timer_value, main_light, side_light, walk};
  endfunction

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the next start_timer pulse; checks latency and the entered phase.
  task automatic wait_entry(input string name, input int exp_n, input logic [3:0] tv,
                            input logic [2:0] m, input logic [2:0] s, input logic w);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!start_timer && n < 8);
    check({name, " outputs"}, obs(), {1'b1, tv, m, s, w});
    check({name, " latency"}, 12'(n), 12'(exp_n));
    $display("entry %s after %0d cycles: tv=%0d main=%b side=%b walk=%b",
             name, n, timer_value, main_light, side_light, walk);
  endtask

  // Reference model: phase indices 0 INIT,1 MAIN_GO,2 MAIN_EXT,3 MAIN_YEL,
  // 4 SIDE_GO,5 SIDE_EXT,6 SIDE_YEL,7 WALK; age counts cycles since the load pulse.
  int         m_phase = 0;
  int         m_age = 0;
  bit         m_pending = 0;
  bit         m_start = 0;
  logic [3:0] m_tv = 4'd0;

  function automatic int succ(input int p, input bit s, input bit pend);
    case (p)
      0: return 1;
      1: return s ? 3 : 2;
      2: return 3;
      3: return pend ? 7 : 4;
      4: return s ? 5 : 6;
      5: return 6;
      6: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] ival(input int p);
    if (p == 1 || p == 4) return 4'd6;
    if (p == 3 || p == 6) return 4'd2;
    return 4'd3;
  endfunction

  function automatic logic [2:0] m_main(input int p);
    if (p == 1 || p == 2) return G;
    if (p == 3) return Y;
    return R;
  endfunction

  function automatic logic [2:0] m_side(input int p);
    if (p == 4 || p == 5) return G;
    if (p == 6) return Y;
    return R;
  endfunction

  task automatic model_step(input bit rst, input bit s, input bit wr, input bit ex);
    int np;
    if (!rst) begin
      m_phase = 0; m_age = 0; m_pending = 0; m_start = 0; m_tv = 4'd0;
    end else if (m_phase == 0 || (ex && m_age >= 2)) begin
      np = succ(m_phase, s, m_pending);
      m_pending = (m_phase == 3 && np == 7) ? 1'b0 : (m_pending | wr);
      m_phase = np;
      m_start = 1;
      m_tv = ival(np);
      m_age = 0;
    end else begin
      m_pending = m_pending | wr;
      m_start = 0;
      if (m_age < 2) m_age++;
    end
  endtask

  logic prev_start;
  logic safe;

  initial begin
    tbl[0]  = mk(0, 0, 0, 0, 0, 4'd0, R, R, 0, "reset");
    tbl[1]  = mk(1, 0, 0, 1, 1, 4'd6, G, R, 0, "init to main_go");
    tbl[2]  = mk(1, 0, 0, 1, 0, 4'd6, G, R, 0, "stale expiry load cycle");
    tbl[3]  = mk(1, 0, 0, 1, 0, 4'd6, G, R, 0, "stale expiry next cycle");
    tbl[4]  = mk(1, 0, 0, 1, 1, 4'd3, G, R, 0, "armed expiry to main_ext");
    tbl[5]  = mk(1, 0, 0, 0, 0, 4'd3, G, R, 0, "main_ext hold");
    tbl[6]  = mk(1, 1, 0, 0, 0, 4'd3, G, R, 0, "main_ext hold sensor");
    tbl[7]  = mk(1, 1, 0, 0, 0, 4'd3, G, R, 0, "armed no expiry");
    tbl[8]  = mk(1, 1, 0, 1, 1, 4'd2, Y, R, 0, "main_ext to main_yel");
    tbl[9]  = mk(1, 0, 0, 0, 0, 4'd2, Y, R, 0, "main_yel hold");
    tbl[10] = mk(1, 0, 0, 0, 0, 4'd2, Y, R, 0, "main_yel hold 2");
    tbl[11] = mk(1, 0, 0, 1, 1, 4'd6, R, G, 0, "main_yel to side_go");
    tbl[12] = mk(1, 0, 0, 0, 0, 4'd6, R, G, 0, "side_go value held");

    for (int i = 0; i < 13; i++) begin
      sys_reset = tbl[i].rst; sensor = tbl[i].sens;
      walk_request = tbl[i].wreq; expired = tbl[i].ex;
      tick();
      check(tbl[i].note, obs(), tbl[i].want);
      $display("vec %0d %s: out=%b", i, tbl[i].note, obs());
    end

    // Sensor held high: short main phase, extended side phase.
    sys_reset = 0; tick(); sys_reset = 1;
    sensor = 1; expired = 1;
    wait_entry("s1 main_go", 1, 4'd6, G, R, 0);
    wait_entry("s1 main_yel", 3, 4'd2, Y, R, 0);
    wait_entry("s1 side_go", 3, 4'd6, R, G, 0);
    wait_entry("s1 side_ext", 3, 4'd3, R, G, 0);
    wait_entry("s1 side_yel", 3, 4'd2, R, Y, 0);
    wait_entry("s1 main_go again", 3, 4'd6, G, R, 0);

    // One-cycle walk request during main green is served after main yellow.
    sys_reset = 0; tick(); sys_reset = 1;
    sensor = 0; expired = 1;
    wait_entry("w main_go", 1, 4'd6, G, R, 0);
    walk_request = 1; tick(); walk_request = 0;
    wait_entry("w main_ext", 2, 4'd3, G, R, 0);
    wait_entry("w main_yel", 3, 4'd2, Y, R, 0);
    wait_entry("w walk", 3, 4'd3, R, R, 1);
    wait_entry("w side_go", 3, 4'd6, R, G, 0);

    // Reset on the edge where an armed expiry would leave side_go.
    tick(); tick();
    sys_reset = 0; tick();
    check("reset overrides expiry", obs(), {1'b0, 4'd0, R, R, 1'b0});
    $display("mid-interval reset: out=%b", obs());
    sys_reset = 1; tick();
    check("restart after reset", obs(), {1'b1, 4'd6, G, R, 1'b0});
    $display("restart: out=%b", obs());

    // Randomized run against the reference model.
    prev_start = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      sys_reset    = (i == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
      sensor       = 1'($urandom_range(0, 1));
      walk_request = ($urandom_range(0, 9) == 0);
      expired      = ($urandom_range(0, 2) == 0);
      model_step(sys_reset, sensor, walk_request, expired);
      tick();
      check("random vs model", obs(),
            {m_start, m_tv, m_main(m_phase), m_side(m_phase), (m_phase == 7)});
      safe = $onehot(main_light) && $onehot(side_light) &&
             (main_light == R || side_light == R) &&
             (!walk || (main_light == R && side_light == R));
      check("lamp safety", 12'(safe), 12'd1);
      check("start pulse width", 12'(prev_start && start_timer), 12'd0);
      prev_start = start_timer;
    end
    $display("random run: 10000 cycles");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/light_sequencer.md
LIGHT_SEQUENCER -- requirements
Module: light_sequencer

Interface
REQ-001 Parameter T_BASE, default 4'd6, base green interval in timer ticks.
REQ-002 Parameter T_EXT, default 4'd3, green-extension and walk interval in timer ticks.
REQ-003 Parameter T_YEL, default 4'd2, yellow interval in timer ticks.
REQ-004 Port clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port sys_reset  input  1  synchronous, active-low reset.
REQ-006 Port sensor  input  1  side-street vehicle present, level, synchronous to clk.
REQ-007 Port walk_request  input  1  pedestrian button, pulse of one or more cycles.
REQ-008 Port expired  input  1  timer expiry flag from the interval timer.
REQ-009 Port start_timer  output  1  one-cycle pulse that loads and starts the interval timer.
REQ-010 Port timer_value  output  4  interval presented to the timer; valid whenever start_timer=1.
REQ-011 Port main_light  output  3  main-street lamps {red,yellow,green}, one-hot.
REQ-012 Port side_light  output  3  side-street lamps {red,yellow,green}, one-hot.
REQ-013 Port walk  output  1  pedestrian walk lamp.

Function
REQ-014 States: INIT, MAIN_GO, MAIN_EXT, MAIN_YEL, SIDE_GO, SIDE_EXT, SIDE_YEL, WALK; all outputs SHALL be registered.
REQ-015 Lamps per state: MAIN_GO/MAIN_EXT main=G side=R; MAIN_YEL main=Y side=R; SIDE_GO/SIDE_EXT main=R side=G; SIDE_YEL main=R side=Y; INIT/WALK main=R side=R; walk=1 only in WALK.
REQ-016 INIT SHALL unconditionally move to MAIN_GO on the first clock with sys_reset=1.
REQ-017 Every state entry SHALL assert start_timer for exactly that one cycle with timer_value = interval of the entered state: MAIN_GO/SIDE_GO T_BASE, MAIN_EXT/SIDE_EXT/WALK T_EXT, MAIN_YEL/SIDE_YEL T_YEL.
REQ-018 timer_value SHALL hold its last loaded value between start_timer pulses.
REQ-019 An armed flag SHALL clear on every start_timer cycle and set on the following cycle; expired SHALL be ignored while armed=0 (stale-expiry guard).
REQ-020 Transitions occur only on an edge where armed=1 and expired=1; the new state, lamps and start_timer pulse SHALL be visible the cycle after that edge (1-cycle latency).
REQ-021 MAIN_GO: sensor=1 -> MAIN_YEL; sensor=0 -> MAIN_EXT.
REQ-022 MAIN_EXT -> MAIN_YEL regardless of sensor.
REQ-023 MAIN_YEL: walk_pending=1 -> WALK; else -> SIDE_GO.
REQ-024 SIDE_GO: sensor=1 -> SIDE_EXT; sensor=0 -> SIDE_YEL.
REQ-025 SIDE_EXT -> SIDE_YEL; SIDE_YEL -> MAIN_GO; WALK -> SIDE_GO.
REQ-026 walk_pending SHALL set on any cycle with walk_request=1 and clear on the MAIN_YEL->WALK transition edge; a request on that same edge SHALL be absorbed (clear wins).
REQ-027 Requests during WALK SHALL re-set walk_pending and be served on the next MAIN_YEL exit.
REQ-028 Main and side lamps SHALL never be simultaneously non-red; walk=1 SHALL imply both red.
REQ-029 No encoding of the state register SHALL be reachable outside the eight listed states; any illegal encoding SHALL recover to INIT next cycle.

Reset
REQ-030 On a clk edge with sys_reset=0: state=INIT, main_light=3'b100, side_light=3'b100, walk=0, start_timer=0, timer_value=4'd0, armed=0, walk_pending=0.
REQ-031 Reset asserted mid-interval SHALL override any pending transition or start_timer pulse in that cycle.

Verification
REQ-032 Release reset, sensor=0, no walk -> start_timer with 6, then expired -> MAIN_EXT with 3, expired -> MAIN_YEL with 2, expired -> SIDE_GO with 6.
REQ-033 sensor=1 constant -> cycle MAIN_GO(6)->MAIN_YEL(2)->SIDE_GO(6)->SIDE_EXT(3)->SIDE_YEL(2)->MAIN_GO(6).
REQ-034 walk_request 1-cycle pulse during MAIN_GO -> after MAIN_YEL, WALK entered with timer_value=3, walk=1, both red; then SIDE_GO.
REQ-035 expired held high during the start_timer cycle and its successor -> no transition; transition only on the later armed expiry.
REQ-036 sys_reset=0 for one cycle during SIDE_GO with expired=1 -> INIT, all red, no start_timer; MAIN_GO with 6 one cycle after release.
REQ-037 Random sensor/walk/expired for 10,000 cycles -> REQ-028 never violated; each start_timer exactly one cycle wide.
